// File: rtl/clkdiv_pkg.sv
// Shared definitions for the sysclk divider bank.
//   CNT_W_DEFAULT      default counter / half-period width
//   HALF_CORE_DEFAULT  half-period for the core clock channel
//   HALF_LED_DEFAULT   half-period for the LED-scan clock channel
//   clamp_half()       max(value, 1); a half-period of zero is never legal
package clkdiv_pkg;

    localparam int unsigned CNT_W_DEFAULT     = 32;
    localparam int unsigned HALF_CORE_DEFAULT = 50000000;
    localparam int unsigned HALF_LED_DEFAULT  = 50000;

    // Callers cast in and out of 64 bits so one function serves any CNT_W.
    function automatic logic [63:0] clamp_half(input logic [63:0] value);
        return (value == 64'd0) ? 64'd1 : value;
    endfunction

endpackage

// File: rtl/clk_divider_chan.sv
// One divider channel: half-period counter, active/shadow half-period and
// registered outputs.
//   sysclk      system clock, rising edge
//   reset       asynchronous, active-high
//   en          run enable; low forces the output low and the phase to zero
//   cfg_we      write strobe for this channel
//   cfg_half    new half-period in sysclk cycles (0 is treated as 1)
//   clk_out     divided clock, 50% duty, period 2*half_act
//   tick        one-cycle pulse coincident with the clk_out rising edge
//   cfg_pending shadow half-period waiting for the next toggle boundary
module clk_divider_chan
    import clkdiv_pkg::*;
#(
    parameter int unsigned CNT_W        = CNT_W_DEFAULT,
    parameter int unsigned DEFAULT_HALF = HALF_CORE_DEFAULT
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             en,
    input  logic             cfg_we,
    input  logic [CNT_W-1:0] cfg_half,
    output logic             clk_out,
    output logic             tick,
    output logic             cfg_pending
);

    localparam logic [CNT_W-1:0] RST_HALF =
        CNT_W'(clamp_half(64'(CNT_W'(DEFAULT_HALF))));

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] half_act;
    logic [CNT_W-1:0] half_shd;
    logic [CNT_W-1:0] half_wr;
    logic             boundary;

    assign half_wr  = CNT_W'(clamp_half(64'(cfg_half)));
    assign boundary = (cnt == half_act - CNT_W'(1));

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            clk_out     <= 1'b0;
            tick        <= 1'b0;
            cfg_pending <= 1'b0;
            half_act    <= RST_HALF;
            half_shd    <= RST_HALF;
        end else begin
            if (!en) begin
                cnt     <= '0;
                clk_out <= 1'b0;
                tick    <= 1'b0;
                if (cfg_pending) begin
                    half_act    <= half_shd;
                    cfg_pending <= 1'b0;
                end
            end else if (boundary) begin
                cnt     <= '0;
                clk_out <= ~clk_out;
                tick    <= ~clk_out;
                // half_act only changes here, where cnt restarts at 0, so cnt
                // can never sit above the new terminal count.
                if (cfg_pending) begin
                    half_act    <= half_shd;
                    cfg_pending <= 1'b0;
                end
            end else begin
                cnt  <= cnt + CNT_W'(1);
                tick <= 1'b0;
            end

            // Placed last so a write landing on a boundary (or while disabled)
            // overrides the pending clear above: the old shadow is applied and
            // the new value waits for the following boundary.
            if (cfg_we) begin
                half_shd    <= half_wr;
                cfg_pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_divider_bank.sv
// Bank of independent sysclk dividers with glitch-free runtime reprogramming.
//   sysclk      system clock, rising edge
//   reset       asynchronous, active-high
//   en          per-channel run enable
//   cfg_we      one-cycle write strobe for a new half-period
//   cfg_ch      target channel; values >= NUM_CH are ignored
//   cfg_half    new half-period in sysclk cycles (0 is treated as 1)
//   clk_out     divided clocks
//   tick        per-channel pulse on each clk_out rising edge
//   cfg_pending per-channel flag, shadow value not yet applied
module clk_divider_bank
    import clkdiv_pkg::*;
#(
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned CNT_W        = CNT_W_DEFAULT,
    parameter int unsigned DEFAULT_HALF = HALF_CORE_DEFAULT,
    parameter int unsigned CH_W         = 1
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] en,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] cfg_pending
);

    // Full-width compare per channel: an out-of-range cfg_ch matches no
    // channel, so the write simply falls on the floor.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic we_ch;

        assign we_ch = cfg_we && (cfg_ch == CH_W'(g));

        clk_divider_chan #(
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_chan (
            .sysclk      (sysclk),
            .reset       (reset),
            .en          (en[g]),
            .cfg_we      (we_ch),
            .cfg_half    (cfg_half),
            .clk_out     (clk_out[g]),
            .tick        (tick[g]),
            .cfg_pending (cfg_pending[g])
        );
    end

endmodule
